// File: rtl/usb_in_ep_buf.sv
// IN endpoint packet buffer: collects a packet from the endpoint function and
// answers IN tokens with DATA0/DATA1 payload, NAK or STALL, and tracks the data toggle.
module usb_in_ep_buf #(
    parameter int MAX_PKT_SIZE = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_ep_req,
    output logic       in_ep_grant,
    output logic       in_ep_data_free,
    input  logic       in_ep_data_put,
    input  logic [7:0] in_ep_data,
    input  logic       in_ep_data_done,
    input  logic       in_ep_stall,
    output logic       in_ep_acked,
    input  logic       in_token,
    input  logic       setup_token,
    input  logic       rx_ack,
    input  logic       hs_timeout,
    output logic       tx_pkt_start,
    output logic [3:0] tx_pid,
    output logic       tx_data_avail,
    input  logic       tx_data_get,
    output logic [7:0] tx_data
);
    localparam int         AW        = (MAX_PKT_SIZE > 1) ? $clog2(MAX_PKT_SIZE) : 1;
    localparam logic [5:0] MAXP      = 6'(MAX_PKT_SIZE);
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [2:0] {FILL, READY, SEND, WAIT_HS, STALLED} state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_buf [0:MAX_PKT_SIZE-1];
    logic [5:0] r_wr_ptr, r_rd_ptr, w_wr_nxt, w_rd_nxt;
    logic       r_toggle, w_toggle_nxt;
    logic [3:0] r_tx_pid, w_pid_nxt;
    logic       r_tx_pkt_start, w_start_nxt;
    logic       r_acked, w_acked_nxt;
    logic       w_wr_en;
    logic [3:0] w_data_pid;

    // Grant is qualified by reset so every output reads 0 while reset is held.
    assign in_ep_grant     = reset && in_ep_req && (r_state == FILL);
    assign in_ep_data_free = in_ep_grant && (r_wr_ptr < MAXP);
    assign tx_data_avail   = (r_state == SEND) && (r_rd_ptr < r_wr_ptr);
    assign tx_data         = tx_data_avail ? r_buf[r_rd_ptr[AW-1:0]] : '0;
    assign tx_pkt_start    = r_tx_pkt_start;
    assign tx_pid          = r_tx_pid;
    assign in_ep_acked     = r_acked;
    assign w_data_pid      = r_toggle ? PID_DATA1 : PID_DATA0;

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_nxt     = r_wr_ptr;
        w_rd_nxt     = r_rd_ptr;
        w_toggle_nxt = r_toggle;
        w_pid_nxt    = r_tx_pid;
        w_start_nxt  = 1'b0;
        w_acked_nxt  = 1'b0;
        w_wr_en      = 1'b0;
        if (setup_token) begin
            w_state_nxt  = FILL;
            w_wr_nxt     = '0;
            w_rd_nxt     = '0;
            w_toggle_nxt = 1'b1;
        end else if (in_ep_stall) begin
            w_state_nxt = STALLED;
        end else begin
            case (r_state)
                FILL: begin
                    if (in_ep_data_put && in_ep_data_free) begin
                        w_wr_en  = 1'b1;
                        w_wr_nxt = r_wr_ptr + 6'd1;
                    end
                    if (in_ep_data_done || (r_wr_ptr == MAXP))
                        w_state_nxt = READY;
                    if (in_token) begin
                        w_start_nxt = 1'b1;
                        w_pid_nxt   = PID_NAK;
                    end
                end
                READY: begin
                    if (in_token) begin
                        w_start_nxt = 1'b1;
                        w_pid_nxt   = w_data_pid;
                        w_rd_nxt    = '0;
                        w_state_nxt = SEND;
                    end
                end
                SEND: begin
                    if (tx_data_avail && tx_data_get)
                        w_rd_nxt = r_rd_ptr + 6'd1;
                    if (w_rd_nxt == r_wr_ptr)
                        w_state_nxt = WAIT_HS;
                end
                WAIT_HS: begin
                    if (rx_ack) begin
                        w_toggle_nxt = ~r_toggle;
                        w_acked_nxt  = 1'b1;
                        w_wr_nxt     = '0;
                        w_state_nxt  = FILL;
                    end else if (in_token) begin
                        // A new IN while awaiting a handshake means the host lost it: resend.
                        w_start_nxt = 1'b1;
                        w_pid_nxt   = w_data_pid;
                        w_rd_nxt    = '0;
                        w_state_nxt = SEND;
                    end else if (hs_timeout) begin
                        w_state_nxt = READY;
                    end
                end
                STALLED: begin
                    if (in_token) begin
                        w_start_nxt = 1'b1;
                        w_pid_nxt   = PID_STALL;
                    end
                end
                default: w_state_nxt = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= FILL;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_toggle       <= 1'b0;
            r_tx_pid       <= '0;
            r_tx_pkt_start <= 1'b0;
            r_acked        <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_nxt;
            r_rd_ptr       <= w_rd_nxt;
            r_toggle       <= w_toggle_nxt;
            r_tx_pid       <= w_pid_nxt;
            r_tx_pkt_start <= w_start_nxt;
            r_acked        <= w_acked_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_buf[r_wr_ptr[AW-1:0]] <= in_ep_data;
    end
endmodule

// File: tb/tb_usb_in_ep_buf.sv
// Scoreboard bench for usb_in_ep_buf: bytes queued as they are put, popped as the DUT sends them.
module tb_usb_in_ep_buf;
    localparam int         MAXP      = 32;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_ep_req = 1'b0, in_ep_data_put = 1'b0, in_ep_data_done = 1'b0;
    logic       in_ep_stall = 1'b0, in_token = 1'b0, setup_token = 1'b0;
    logic       rx_ack = 1'b0, hs_timeout = 1'b0, tx_data_get = 1'b0;
    logic [7:0] in_ep_data = '0;
    logic       in_ep_grant, in_ep_data_free, in_ep_acked, tx_pkt_start, tx_data_avail;
    logic [3:0] tx_pid;
    logic [7:0] tx_data;

    int         errors = 0;
    int         checks = 0;
    int         ack_cnt = 0;
    int         a0;
    logic [7:0] e;
    logic [7:0] sbq[$];
    logic [7:0] last_pkt[$];

    usb_in_ep_buf #(.MAX_PKT_SIZE(MAXP)) dut (
        .clk(clk), .reset(reset),
        .in_ep_req(in_ep_req), .in_ep_grant(in_ep_grant),
        .in_ep_data_free(in_ep_data_free), .in_ep_data_put(in_ep_data_put),
        .in_ep_data(in_ep_data), .in_ep_data_done(in_ep_data_done),
        .in_ep_stall(in_ep_stall), .in_ep_acked(in_ep_acked),
        .in_token(in_token), .setup_token(setup_token),
        .rx_ack(rx_ack), .hs_timeout(hs_timeout),
        .tx_pkt_start(tx_pkt_start), .tx_pid(tx_pid),
        .tx_data_avail(tx_data_avail), .tx_data_get(tx_data_get),
        .tx_data(tx_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (in_ep_acked) ack_cnt <= ack_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input logic [7:0] base, input bit done_last);
        last_pkt.delete();
        for (int i = 0; i < n; i++) begin
            in_ep_data_put  = 1'b1;
            in_ep_data      = base + 8'(i);
            in_ep_data_done = done_last && (i == n - 1);
            check("data_free", 32'(in_ep_data_free), 1);
            sbq.push_back(in_ep_data);
            last_pkt.push_back(in_ep_data);
            step();
        end
        in_ep_data_put  = 1'b0;
        in_ep_data_done = 1'b0;
        if (!done_last) begin
            in_ep_data_done = 1'b1;
            step();
            in_ep_data_done = 1'b0;
        end
        check("commit_grant", 32'(in_ep_grant), 0);
    endtask

    task automatic token(input string tag, input logic [3:0] exp_pid);
        in_token = 1'b1;
        step();
        in_token = 1'b0;
        check({tag, "_start"}, 32'(tx_pkt_start), 1);
        check({tag, "_pid"}, 32'(tx_pid), 32'(exp_pid));
    endtask

    task automatic recv(input string tag, input logic [3:0] exp_pid);
        int n;
        int exp_n;
        logic [7:0] x;
        n = 0;
        exp_n = sbq.size();
        for (int c = 0; c < 200; c++) begin
            if (!tx_data_avail) break;
            n++;
            if (sbq.size() == 0) break;
            x = sbq.pop_front();
            check({tag, "_data"}, 32'(tx_data), 32'(x));
            tx_data_get = 1'b1;
            step();
            tx_data_get = 1'b0;
        end
        check({tag, "_count"}, 32'(n), 32'(exp_n));
        step();
        check({tag, "_avail_off"}, 32'(tx_data_avail), 0);
        check({tag, "_pid_hold"}, 32'(tx_pid), 32'(exp_pid));
    endtask

    task automatic ack(input string tag);
        int base;
        base = ack_cnt;
        rx_ack = 1'b1;
        step();
        rx_ack = 1'b0;
        check({tag, "_acked"}, 32'(in_ep_acked), 1);
        step();
        check({tag, "_acked_low"}, 32'(in_ep_acked), 0);
        check({tag, "_ack_pulses"}, 32'(ack_cnt - base), 1);
    endtask

    initial begin
        in_ep_req = 1'b1;
        repeat (3) step();
        check("rst_grant", 32'(in_ep_grant), 0);
        check("rst_free", 32'(in_ep_data_free), 0);
        check("rst_pid", 32'(tx_pid), 0);
        check("rst_start", 32'(tx_pkt_start), 0);
        check("rst_avail", 32'(tx_data_avail), 0);
        check("rst_acked", 32'(in_ep_acked), 0);
        reset = 1'b1;
        step();
        check("post_rst_grant", 32'(in_ep_grant), 1);
        check("post_rst_free", 32'(in_ep_data_free), 1);

        // 18-byte packet after SETUP goes out as DATA1, the next one as DATA0
        setup_token = 1'b1; step(); setup_token = 1'b0;
        fill(18, 8'h12, 1'b0);
        token("p18", PID_DATA1);
        recv("p18", PID_DATA1);
        ack("p18");
        fill(3, 8'hA0, 1'b1);
        token("p3", PID_DATA0);
        recv("p3", PID_DATA0);
        ack("p3");

        // zero-length packet: no payload, handshake still accepted
        setup_token = 1'b1; step(); setup_token = 1'b0;
        fill(0, 8'h00, 1'b0);
        token("zlp", PID_DATA1);
        check("zlp_avail", 32'(tx_data_avail), 0);
        recv("zlp", PID_DATA1);
        ack("zlp");

        // overfill: 33rd put ignored, auto-commit
        for (int i = 0; i < 33; i++) begin
            in_ep_data_put = 1'b1;
            in_ep_data     = 8'h40 + 8'(i);
            check("free_33", 32'(in_ep_data_free), 32'(i < 32));
            if (i < 32) sbq.push_back(in_ep_data);
            step();
        end
        in_ep_data_put = 1'b0;
        check("auto_commit_grant", 32'(in_ep_grant), 0);
        token("full", PID_DATA0);
        recv("full", PID_DATA0);
        ack("full");

        // NAK while filling, then timeout and token-driven retransmits
        token("nak", PID_NAK);
        check("nak_avail", 32'(tx_data_avail), 0);
        step();
        check("nak_start_pulse", 32'(tx_pkt_start), 0);
        check("nak_pid_hold", 32'(tx_pid), 32'(PID_NAK));
        fill(5, 8'hC3, 1'b1);
        token("tx1", PID_DATA1);
        recv("tx1", PID_DATA1);
        hs_timeout = 1'b1; step(); hs_timeout = 1'b0;
        sbq = last_pkt;
        token("retx_to", PID_DATA1);
        recv("retx_to", PID_DATA1);
        sbq = last_pkt;
        token("retx_tok", PID_DATA1);
        recv("retx_tok", PID_DATA1);
        ack("retx");

        // stall, then setup coinciding with stall wins
        in_ep_stall = 1'b1; step(); in_ep_stall = 1'b0;
        check("stall_grant", 32'(in_ep_grant), 0);
        token("stall", PID_STALL);
        check("stall_avail", 32'(tx_data_avail), 0);
        setup_token = 1'b1; in_ep_stall = 1'b1; step();
        setup_token = 1'b0; in_ep_stall = 1'b0;
        check("setup_stall_grant", 32'(in_ep_grant), 1);
        fill(0, 8'h00, 1'b0);
        token("setup_stall", PID_DATA1);
        recv("setup_stall", PID_DATA1);
        ack("setup_stall");

        // reset in the middle of sending
        fill(10, 8'h80, 1'b0);
        token("mid", PID_DATA0);
        for (int i = 0; i < 5; i++) begin
            check("mid_avail", 32'(tx_data_avail), 1);
            e = sbq.pop_front();
            check("mid_data", 32'(tx_data), 32'(e));
            tx_data_get = 1'b1; step(); tx_data_get = 1'b0;
        end
        a0 = ack_cnt;
        reset = 1'b0;
        #1;
        check("mrst_pid", 32'(tx_pid), 0);
        check("mrst_avail", 32'(tx_data_avail), 0);
        check("mrst_data", 32'(tx_data), 0);
        check("mrst_start", 32'(tx_pkt_start), 0);
        check("mrst_grant", 32'(in_ep_grant), 0);
        repeat (3) step();
        reset = 1'b1;
        step();
        sbq.delete();
        check("mrst_no_ack", 32'(ack_cnt - a0), 0);
        check("mrst_fill_grant", 32'(in_ep_grant), 1);
        check("mrst_fill_free", 32'(in_ep_data_free), 1);
        fill(0, 8'h00, 1'b0);
        token("mrst_tok", PID_DATA0);
        recv("mrst", PID_DATA0);
        ack("mrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/usb_in_ep_buf.md
USB_IN_EP_BUF -- requirements
Module: usb_in_ep_buf

Interface
REQ-001 SHALL have parameter MAX_PKT_SIZE, default 32, meaning max bytes per IN data packet (1..63).
REQ-002 SHALL run on one clock; reset is asynchronous and active-low (ports clk, reset).
REQ-003 SHALL have port clk  in  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous active-low reset, asserted at 0.
REQ-005 SHALL have port in_ep_req  in  1  endpoint function requests buffer ownership.
REQ-006 SHALL have port in_ep_grant  out  1  ownership granted.
REQ-007 SHALL have port in_ep_data_free  out  1  buffer accepts a byte this cycle.
REQ-008 SHALL have port in_ep_data_put  in  1  write in_ep_data this cycle.
REQ-009 SHALL have port in_ep_data  in  8  byte to write.
REQ-010 SHALL have port in_ep_data_done  in  1  commit current contents (incl. zero-length) as a packet.
REQ-011 SHALL have port in_ep_stall  in  1  pulse, stall the endpoint.
REQ-012 SHALL have port in_ep_acked  out  1  pulse, host ACKed the committed packet.
REQ-013 SHALL have port in_token  in  1  pulse, IN token addressed to this endpoint.
REQ-014 SHALL have port setup_token  in  1  pulse, SETUP token addressed to this endpoint.
REQ-015 SHALL have port rx_ack  in  1  pulse, host ACK handshake received.
REQ-016 SHALL have port hs_timeout  in  1  pulse, handshake wait timed out.
REQ-017 SHALL have port tx_pkt_start  out  1  pulse, begin a response packet.
REQ-018 SHALL have port tx_pid  out  4  PID of response: DATA0 0011, DATA1 1011, NAK 1010, STALL 1110.
REQ-019 SHALL have port tx_data_avail  out  1  a payload byte is on tx_data.
REQ-020 SHALL have port tx_data_get  in  1  protocol engine consumes tx_data this cycle.
REQ-021 SHALL have port tx_data  out  8  current payload byte, buf[rd_ptr].

Function
REQ-022 SHALL hold a MAX_PKT_SIZE x 8 buffer, 6-bit wr_ptr (byte count) and 6-bit rd_ptr, a data toggle bit, and state machine FILL, READY, SEND, WAIT_HS, STALLED.
REQ-023 SHALL drive in_ep_grant = in_ep_req && state==FILL; in_ep_data_free = grant && wr_ptr<MAX_PKT_SIZE.
REQ-024 SHALL, in FILL on put && data_free, write buf[wr_ptr] and increment wr_ptr; put with data_free low SHALL be ignored.
REQ-025 SHALL go FILL->READY on in_ep_data_done, or the cycle after wr_ptr reaches MAX_PKT_SIZE; a put coinciding with done SHALL be included.
REQ-026 SHALL answer in_token in FILL with tx_pkt_start and tx_pid=NAK next cycle, no payload, state unchanged.
REQ-027 SHALL, in READY on in_token, pulse tx_pkt_start next cycle with tx_pid DATA0/DATA1 per toggle, clear rd_ptr, enter SEND.
REQ-028 SHALL, in SEND, assert tx_data_avail while rd_ptr<wr_ptr; each tx_data_get increments rd_ptr; enter WAIT_HS when rd_ptr==wr_ptr (immediately for zero-length).
REQ-029 SHALL, in WAIT_HS on rx_ack, flip toggle, pulse in_ep_acked one cycle, clear wr_ptr, enter FILL.
REQ-030 SHALL, in WAIT_HS on hs_timeout, return to READY, retaining data and toggle; in_token in WAIT_HS SHALL act as timeout followed by REQ-027 (retransmit).
REQ-031 SHALL enter STALLED on in_ep_stall from any state; in STALLED, in_token answered with tx_pid=STALL, no payload.
REQ-032 SHALL, on setup_token in any state, clear wr_ptr/rd_ptr, set toggle to DATA1, leave STALLED, enter FILL.
REQ-033 SHALL apply priority reset > setup_token > in_ep_stall > all other events when simultaneous.
REQ-034 SHALL keep tx_pid stable from tx_pkt_start until the next tx_pkt_start.

Reset
REQ-035 SHALL, while reset=0, force state FILL, wr_ptr=rd_ptr=0, toggle DATA0, all outputs 0 (tx_pid 0000); buffer contents undefined.
REQ-036 SHALL discard any in-progress packet on reset mid-SEND/WAIT_HS with no in_ep_acked pulse.

Verification
REQ-037 SHALL cover: setup_token, put 18 bytes 0x12..., done, in_token -> tx_pid DATA1, 18 bytes in order, rx_ack -> one in_ep_acked pulse, next packet DATA0.
REQ-038 SHALL cover: done with no puts, in_token -> tx_pid DATA1, tx_data_avail never high, WAIT_HS entered.
REQ-039 SHALL cover: 33 puts with MAX_PKT_SIZE=32 -> data_free low after 32nd, 33rd ignored, auto-commit to READY.
REQ-040 SHALL cover: in_token in FILL -> NAK; packet sent then hs_timeout, in_token -> same PID, same bytes retransmitted.
REQ-041 SHALL cover: in_ep_stall then in_token -> STALL PID; setup_token same cycle as in_ep_stall -> FILL, toggle DATA1.
REQ-042 SHALL cover: reset=0 mid-SEND after 5 of 10 bytes -> outputs 0, state FILL, no in_ep_acked.
